fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl_if.sv | 69 ++++++
 rtl/fifo_rd_ctrl.sv | 131 +++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// rtl/fifo_rd_ctrl_if.sv - FIFO-side and downstream-side bundle for fifo_rd_ctrl
//
// Parameters:
//   DB - data width
//   AB - address width
//   CB - command width
//
// Signals:
//   fifo_rd_o        controller -> FIFO   read enable, one pop per cycle
//   fifo_empty_i     FIFO -> controller   empty flag
//   fifo_den_i       FIFO -> controller   read data valid, one cycle after a read
//   fifo_data_i      FIFO -> controller   read data field
//   fifo_address_i   FIFO -> controller   read address field
//   fifo_command_i   FIFO -> controller   read command field
//   m_valid_o        controller -> sink   transaction valid
//   m_ready_i        sink -> controller   transaction ready
//   m_data_o         controller -> sink   data field
//   m_address_o      controller -> sink   address field
//   m_command_o      controller -> sink   command field
//
// Modports:
//   master - the read controller
//   slave  - the FIFO and downstream sink surrounding it

interface fifo_rd_ctrl_if #(
  parameter int DB = 64,
  parameter int AB = 64,
  parameter int CB = 8
);
  logic          fifo_rd_o;
  logic          fifo_empty_i;
  logic          fifo_den_i;
  logic [DB-1:0] fifo_data_i;
  logic [AB-1:0] fifo_address_i;
  logic [CB-1:0] fifo_command_i;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [DB-1:0] m_data_o;
  logic [AB-1:0] m_address_o;
  logic [CB-1:0] m_command_o;

  modport master (
    output fifo_rd_o,
    input  fifo_empty_i,
    input  fifo_den_i,
    input  fifo_data_i,
    input  fifo_address_i,
    input  fifo_command_i,
    output m_valid_o,
    input  m_ready_i,
    output m_data_o,
    output m_address_o,
    output m_command_o
  );

  modport slave (
    input  fifo_rd_o,
    output fifo_empty_i,
    output fifo_den_i,
    output fifo_data_i,
    output fifo_address_i,
    output fifo_command_i,
    input  m_valid_o,
    output m_ready_i,
    input  m_data_o,
    input  m_address_o,
    input  m_command_o
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - drains a FIFO into a valid/ready stream through a 2-entry buffer
//
// Parameters:
//   DB, AB, CB - data, address and command widths (must match the bus instance)
//
// Ports:
//   clk_i       single clock, rising edge
//   rst_i       synchronous active-high reset
//   drain_en_i  allows new FIFO reads to be issued
//   bus         fifo_rd_ctrl_if.master: FIFO read side and downstream stream
//   pop_cnt_o   entries accepted from the FIFO, wraps at 16 bits
//   xfer_cnt_o  downstream handshakes, wraps at 16 bits
//   err_o       sticky protocol error, cleared only by reset

module fifo_rd_ctrl #(
  parameter int DB = 64,
  parameter int AB = 64,
  parameter int CB = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        drain_en_i,
  fifo_rd_ctrl_if.master bus,
  output logic [15:0] pop_cnt_o,
  output logic [15:0] xfer_cnt_o,
  output logic        err_o
);

  localparam int EW = DB + AB + CB;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  occ_e          occ_q;
  logic          inflight_q;
  logic [EW-1:0] head_q;
  logic [EW-1:0] tail_q;
  logic [15:0]   pop_cnt_q;
  logic [15:0]   xfer_cnt_q;
  logic          err_q;

  logic          m_valid;
  logic          pop;
  logic          push;
  logic          push_ok;
  logic          rd;
  logic [2:0]    pending;
  logic          err_evt;
  logic [EW-1:0] new_ent;

  assign new_ent = {bus.fifo_data_i, bus.fifo_address_i, bus.fifo_command_i};

  // Reset dominates so nothing is exposed or requested while rst_i is high.
  assign m_valid = (occ_q != OCC_EMPTY) && !rst_i;
  assign pop     = m_valid && bus.m_ready_i;
  assign push    = bus.fifo_den_i && inflight_q;
  // A push into a full buffer without a same-cycle pop has nowhere to go.
  assign push_ok = push && !((occ_q == OCC_FULL) && !pop);

  // Entries already held or in flight, less the one leaving this cycle.
  // pop is only ever 1 when occ >= 1, so this never underflows.
  always_comb begin
    pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  end

  assign rd = drain_en_i && !bus.fifo_empty_i && !rst_i && (pending <= 3'd1);

  // Missing response, stray response, or overflow.
  assign err_evt = (inflight_q && !bus.fifo_den_i) ||
                   (bus.fifo_den_i && !inflight_q) ||
                   (push && !push_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q      <= OCC_EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      pop_cnt_q  <= '0;
      xfer_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      // Every read gets exactly one response cycle, so inflight simply
      // mirrors whether a read was issued in the previous cycle.
      inflight_q <= rd;

      if (err_evt) err_q <= 1'b1;
      if (push_ok) pop_cnt_q <= pop_cnt_q + 16'd1;
      if (pop) xfer_cnt_q <= xfer_cnt_q + 16'd1;

      case ({push_ok, pop})
        2'b10: begin
          if (occ_q == OCC_EMPTY) begin
            head_q <= new_ent;
            occ_q  <= OCC_ONE;
          end else if (occ_q == OCC_ONE) begin
            tail_q <= new_ent;
            occ_q  <= OCC_FULL;
          end
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= (occ_q == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
        end
        2'b11: begin
          // Occupancy unchanged; the new entry lands behind whatever remains.
          if (occ_q == OCC_FULL) begin
            head_q <= tail_q;
            tail_q <= new_ent;
          end else begin
            head_q <= new_ent;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fifo_rd_o   = rd;
  assign bus.m_valid_o   = m_valid;
  assign bus.m_data_o    = head_q[EW-1 -: DB];
  assign bus.m_address_o = head_q[CB +: AB];
  assign bus.m_command_o = head_q[CB-1:0];
  assign pop_cnt_o       = pop_cnt_q;
  assign xfer_cnt_o      = xfer_cnt_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - self-checking bench for fifo_rd_ctrl

module tb_fifo_rd_ctrl;
  localparam int DB = 64;
  localparam int AB = 64;
  localparam int CB = 8;
  localparam int EW = DB + AB + CB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drain_en = 1'b0;
  logic [15:0] pop_cnt;
  logic [15:0] xfer_cnt;
  logic        err;

  fifo_rd_ctrl_if #(.DB(DB), .AB(AB), .CB(CB)) bus ();

  fifo_rd_ctrl #(.DB(DB), .AB(AB), .CB(CB)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .drain_en_i (drain_en),
    .bus        (bus),
    .pop_cnt_o  (pop_cnt),
    .xfer_cnt_o (xfer_cnt),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  // FIFO model: holds entries rd_ptr .. wr_ptr-1, each entry a pure function of its index.
  logic [31:0] rd_ptr = '0;
  logic [31:0] wr_ptr = '0;
  logic [31:0] exp_ptr = '0;
  logic        kill_den = 1'b0;
  logic        stray_den = 1'b0;
  int          n_vec = 0;
  int          n_miss = 0;

  function automatic logic [EW-1:0] ent(logic [31:0] k);
    logic [DB-1:0] d;
    logic [AB-1:0] a;
    logic [CB-1:0] c;
    d = {k, ~k};
    a = {k ^ 32'h5555_5555, 32'h0000_1000 + k};
    c = k[7:0] ^ 8'h3C;
    return {d, a, c};
  endfunction

  assign bus.fifo_empty_i = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    bus.fifo_den_i     <= (bus.fifo_rd_o && !kill_den) || stray_den;
    bus.fifo_data_i    <= ent(rd_ptr)[EW-1 -: DB];
    bus.fifo_address_i <= ent(rd_ptr)[CB +: AB];
    bus.fifo_command_i <= ent(rd_ptr)[CB-1:0];
    if (bus.fifo_rd_o) rd_ptr <= rd_ptr + 32'd1;
  end

  function automatic logic [EW-1:0] head();
    return {bus.m_data_o, bus.m_address_o, bus.m_command_o};
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge after inputs are set; scores any handshake, returns at the next falling edge.
  task automatic tick();
    #1;
    if (bus.m_valid_o && bus.m_ready_i) begin
      chk("sb_entry", head(), ent(exp_ptr));
      exp_ptr = exp_ptr + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic run_until(input logic [31:0] target, input int budget, input bit rnd);
    int n;
    n = 0;
    while (exp_ptr != target && n < budget) begin
      if (rnd) bus.m_ready_i = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("drain_done", exp_ptr, target);
    bus.m_ready_i = 1'b1;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drain_en = 1'b0;
    bus.m_ready_i = 1'b0;
    kill_den = 1'b0;
    stray_den = 1'b0;
    tick();
    rst = 1'b0;
    wr_ptr = rd_ptr;
    exp_ptr = rd_ptr;
  endtask

  typedef struct {
    logic drain;
    logic ready;
    logic exp_rd;
    logic exp_valid;
    int   exp_idx;
  } vec_t;

  vec_t        tbl[7];
  logic [31:0] base;

  initial begin
    bus.m_ready_i = 1'b0;
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 2};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 3};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 0};

    @(negedge clk);
    do_reset();
    #1;
    chk("rst_valid", bus.m_valid_o, 1'b0);
    chk("rst_fields", head(), '0);
    chk("rst_rd", bus.fifo_rd_o, 1'b0);
    chk("rst_pop_cnt", pop_cnt, 16'd0);
    chk("rst_xfer_cnt", xfer_cnt, 16'd0);
    chk("rst_err", err, 1'b0);

    // Four preloaded entries, free-flowing sink.
    base = rd_ptr;
    wr_ptr = base + 32'd4;
    for (int i = 0; i < 7; i++) begin
      drain_en = tbl[i].drain;
      bus.m_ready_i = tbl[i].ready;
      #1;
      chk("tbl_rd", bus.fifo_rd_o, tbl[i].exp_rd);
      chk("tbl_valid", bus.m_valid_o, tbl[i].exp_valid);
      if (tbl[i].exp_valid) chk("tbl_head", head(), ent(base + 32'(tbl[i].exp_idx)));
      tick();
    end
    chk("flow_pop_cnt", pop_cnt, 16'd4);
    chk("flow_xfer_cnt", xfer_cnt, 16'd4);
    chk("flow_err", err, 1'b0);

    // Five preloaded, sink stalled: exactly two reads, head held.
    base = rd_ptr;
    wr_ptr = base + 32'd5;
    drain_en = 1'b1;
    bus.m_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i >= 3) chk("stall_head", head(), ent(base));
      tick();
    end
    #1;
    chk("stall_reads", rd_ptr - base, 32'd2);
    chk("stall_valid", bus.m_valid_o, 1'b1);
    chk("stall_rd", bus.fifo_rd_o, 1'b0);
    bus.m_ready_i = 1'b1;
    run_until(base + 32'd5, 40, 1'b0);
    chk("stall_all_read", rd_ptr, base + 32'd5);
    chk("stall_pop_cnt", pop_cnt, 16'd9);
    chk("stall_xfer_cnt", xfer_cnt, 16'd9);

    // Reset with a buffered entry and a response in flight.
    do_reset();
    base = rd_ptr;
    wr_ptr = base + 32'd5;
    drain_en = 1'b1;
    bus.m_ready_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("inrst_rd", bus.fifo_rd_o, 1'b0);
    chk("inrst_valid", bus.m_valid_o, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_valid", bus.m_valid_o, 1'b0);
    chk("midrst_fields", head(), '0);
    chk("midrst_pop_cnt", pop_cnt, 16'd0);
    chk("midrst_xfer_cnt", xfer_cnt, 16'd0);
    chk("midrst_err", err, 1'b0);
    chk("midrst_reads", rd_ptr, base + 32'd2);
    exp_ptr = rd_ptr;
    bus.m_ready_i = 1'b1;
    run_until(base + 32'd5, 40, 1'b0);
    chk("resume_pop_cnt", pop_cnt, 16'd3);
    chk("resume_xfer_cnt", xfer_cnt, 16'd3);
    chk("resume_err", err, 1'b0);

    // 100 entries with a randomly toggling sink.
    base = rd_ptr;
    wr_ptr = base + 32'd100;
    drain_en = 1'b1;
    run_until(base + 32'd100, 2000, 1'b1);
    chk("rand_pop_cnt", pop_cnt, 16'd103);
    chk("rand_xfer_cnt", xfer_cnt, 16'd103);
    chk("rand_err", err, 1'b0);

    // Read whose response never comes.
    drain_en = 1'b0;
    base = rd_ptr;
    wr_ptr = base + 32'd1;
    kill_den = 1'b1;
    drain_en = 1'b1;
    tick();
    drain_en = 1'b0;
    kill_den = 1'b0;
    tick();
    #1;
    chk("miss_err", err, 1'b1);
    chk("miss_valid", bus.m_valid_o, 1'b0);
    chk("miss_pop_cnt", pop_cnt, 16'd103);
    repeat (3) tick();
    chk("miss_err_sticky", err, 1'b1);
    exp_ptr = rd_ptr;

    // Stray response arriving on the first cycle after reset.
    rst = 1'b1;
    stray_den = 1'b1;
    tick();
    rst = 1'b0;
    stray_den = 1'b0;
    #1;
    chk("stray_err_pre", err, 1'b0);
    tick();
    #1;
    chk("stray_err", err, 1'b1);
    chk("stray_pop_cnt", pop_cnt, 16'd0);
    chk("stray_valid", bus.m_valid_o, 1'b0);

    // Counter wrap over 65537 transfers.
    do_reset();
    base = rd_ptr;
    wr_ptr = base + 32'd65537;
    drain_en = 1'b1;
    bus.m_ready_i = 1'b1;
    run_until(base + 32'd65537, 65600, 1'b0);
    chk("wrap_pop_cnt", pop_cnt, 16'd1);
    chk("wrap_xfer_cnt", xfer_cnt, 16'd1);
    chk("wrap_err", err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
